// File: rtl/shape_processor_bus_adapter_pkg.sv
// Shared types and widths for the shape_processor bus adapter.
// Optional error counter is enabled with SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN.
package shape_processor_bus_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } adapter_state_e;

    localparam int LAT_CNT_W = 3;
    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/shape_processor_bus_adapter_err_cnt.sv
// Saturating count of error responses; only built under SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN.
module shape_processor_bus_adapter_err_cnt
    import shape_processor_bus_adapter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [ERR_CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/shape_processor_bus_adapter.sv
// Valid/ready front end that turns one request at a time into a shape_processor strobe
// and returns the sampled read_data/error. Macro: SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN adds err_cnt.
module shape_processor_bus_adapter
    import shape_processor_bus_adapter_pkg::*;
#(
    parameter int RSP_LATENCY = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              write,
    output logic [DATA_W-1:0] write_data,
    output logic              read,
    input  logic [DATA_W-1:0] read_data,
    input  logic              error,
    output logic              busy
`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    generate
        if (RSP_LATENCY < 0 || RSP_LATENCY > 7) begin : g_bad_latency
            $error("RSP_LATENCY must be in 0..7");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (RSP_LATENCY > 0) ? LAT_CNT_W'(RSP_LATENCY - 1) : '0;

    logic [1:0]           state;
    logic                 is_write_q;
    logic [LAT_CNT_W-1:0] lat_cnt;

    // NOTE: every register, including the data-path ones, is reset so a mid-flight
    // reset leaves no stale response or strobe behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            is_write_q <= 1'b0;
            lat_cnt    <= '0;
            write_data <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        is_write_q <= req_write;
                        if (req_write) begin
                            write_data <= req_wdata;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (RSP_LATENCY == 0) begin
                        rsp_rdata <= is_write_q ? '0 : read_data;
                        rsp_error <= error;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_rdata <= is_write_q ? '0 : read_data;
                        rsp_error <= error;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: strobes are decoded from state so an asynchronous reset removes them at once.
    assign write     = (state == ST_ISSUE) &&  is_write_q;
    assign read      = (state == ST_ISSUE) && !is_write_q;
    assign rsp_valid = (state == ST_RESP);
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
    logic err_hs;
    assign err_hs = rsp_valid && rsp_ready && rsp_error;

    shape_processor_bus_adapter_err_cnt u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_hs),
        .count (err_cnt)
    );
`endif

endmodule

// File: tb/tb_shape_processor_bus_adapter.sv
// Directed bench: main instance at RSP_LATENCY=1, plus instances at 0 and 7 for sampling timing.
module tb_shape_processor_bus_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_wdata, read_data;
    logic        error;
    logic        req_ready, rsp_valid, rsp_error, write, read, busy;
    logic [31:0] rsp_rdata, write_data;

    logic        req_valid_0, req_ready_0, rsp_valid_0, rsp_error_0, write_0, read_0, busy_0;
    logic [31:0] rsp_rdata_0, write_data_0;
    logic        req_valid_7, req_ready_7, rsp_valid_7, rsp_error_7, write_7, read_7, busy_7;
    logic [31:0] rsp_rdata_7, write_data_7;
    logic        rsp_ready_x;

`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
    logic [15:0] err_cnt, err_cnt_0, err_cnt_7;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    shape_processor_bus_adapter #(.RSP_LATENCY(1), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .write(write), .write_data(write_data), .read(read), .read_data(read_data),
        .error(error), .busy(busy)
`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    shape_processor_bus_adapter #(.RSP_LATENCY(0), .DATA_W(32)) dut_lat0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_0), .req_ready(req_ready_0),
        .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid_0),
        .rsp_ready(rsp_ready_x), .rsp_rdata(rsp_rdata_0), .rsp_error(rsp_error_0),
        .write(write_0), .write_data(write_data_0), .read(read_0), .read_data(read_data),
        .error(error), .busy(busy_0)
`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
        , .err_cnt(err_cnt_0)
`endif
    );

    shape_processor_bus_adapter #(.RSP_LATENCY(7), .DATA_W(32)) dut_lat7 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_7), .req_ready(req_ready_7),
        .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid_7),
        .rsp_ready(rsp_ready_x), .rsp_rdata(rsp_rdata_7), .rsp_error(rsp_error_7),
        .write(write_7), .write_data(write_data_7), .read(read_7), .read_data(read_data),
        .error(error), .busy(busy_7)
`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
        , .err_cnt(err_cnt_7)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
        rsp_ready = 1'b1; read_data = '0; error = 1'b0;
        req_valid_0 = 1'b0; req_valid_7 = 1'b0; rsp_ready_x = 1'b1;
        tick(); tick();

        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_write", write, 0);
        check("rst_read", read, 0);
        check("rst_write_data", write_data, 0);
        check("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        tick();

        // Write with error asserted only in the sampling cycle (T+2).
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0000_0102;
        read_data = 32'hDEAD_BEEF;
        check("wr_T_req_ready", req_ready, 1);
        tick();                                   // T+1
        req_valid = 1'b0; req_wdata = 32'h1111_1111;
        check("wr_T1_write", write, 1);
        check("wr_T1_read", read, 0);
        check("wr_T1_write_data", write_data, 32'h0000_0102);
        check("wr_T1_busy", busy, 1);
        check("wr_T1_req_ready", req_ready, 0);
        tick();                                   // T+2
        error = 1'b1;
        check("wr_T2_write", write, 0);
        check("wr_T2_rsp_valid", rsp_valid, 0);
        tick();                                   // T+3
        error = 1'b0;
        check("wr_T3_rsp_valid", rsp_valid, 1);
        check("wr_T3_rsp_rdata", rsp_rdata, 0);
        check("wr_T3_rsp_error", rsp_error, 1);
        check("wr_T3_req_ready", req_ready, 0);
`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
        check("wr_T3_err_cnt", err_cnt, 0);
`endif
        tick();                                   // T+4, back in IDLE
        check("wr_T4_rsp_valid", rsp_valid, 0);
        check("wr_T4_busy", busy, 0);
        check("wr_T4_req_ready", req_ready, 1);
        check("wr_T4_write_data_hold", write_data, 32'h0000_0102);
`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
        check("wr_T4_err_cnt", err_cnt, 1);
`endif

        // Read with response backpressure; a pending write request waits behind it.
        req_valid = 1'b1; req_write = 1'b0; req_wdata = 32'hFFFF_FFFF;
        rsp_ready = 1'b0; read_data = 32'h0;
        tick();                                   // T+1
        req_write = 1'b1; req_wdata = 32'h0000_0055;
        check("rd_T1_read", read, 1);
        check("rd_T1_write", write, 0);
        check("rd_T1_write_data", write_data, 32'h0000_0102);
        tick();                                   // T+2
        read_data = 32'h0000_0201;
        check("rd_T2_read", read, 0);
        tick();                                   // T+3
        read_data = 32'h0000_0BAD;
        error = 1'b1;
        check("rd_T3_rsp_valid", rsp_valid, 1);
        check("rd_T3_rsp_rdata", rsp_rdata, 32'h0000_0201);
        check("rd_T3_rsp_error", rsp_error, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'h0000_0201);
            check("bp_rsp_error", rsp_error, 0);
            check("bp_req_ready", req_ready, 0);
            check("bp_strobes", {30'b0, write, read}, 0);
        end
        error = 1'b0;
        rsp_ready = 1'b1;
        tick();                                   // handshake done, IDLE
        check("bp_idle_rsp_valid", rsp_valid, 0);
        check("bp_idle_req_ready", req_ready, 1);
        check("bp_idle_write", write, 0);
        tick();                                   // pending write issues now
        req_valid = 1'b0;
        check("bp_next_write", write, 1);
        check("bp_next_write_data", write_data, 32'h0000_0055);
        tick(); tick();
        check("bp_next_rsp_valid", rsp_valid, 1);
        check("bp_next_rsp_error", rsp_error, 0);
        tick();
`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
        check("bp_next_err_cnt", err_cnt, 1);
`endif

        // Reset while the strobe is high: it must drop immediately.
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0000_00AB;
        tick();                                   // T+1
        req_valid = 1'b0;
        check("rsti_write_before", write, 1);
        rst_n = 1'b0;
        #1;
        check("rsti_write_after", write, 0);
        check("rsti_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        // Reset in WAIT: no response afterwards, then a normal read completes.
        tick();
        req_valid = 1'b1; req_write = 1'b0;
        tick();                                   // T+1
        req_valid = 1'b0;
        tick();                                   // T+2 (WAIT)
        check("rstw_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_req_ready", req_ready, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rstw_no_rsp", rsp_valid, 0);
        end
        req_valid = 1'b1; req_write = 1'b0; read_data = 32'h0000_0077;
        tick();
        req_valid = 1'b0;
        check("rstw_read", read, 1);
        tick(); tick();
        check("rstw_rsp_valid", rsp_valid, 1);
        check("rstw_rsp_rdata", rsp_rdata, 32'h0000_0077);
        tick();
        check("rstw_done", busy, 0);

`ifdef SHAPE_PROCESSOR_BUS_ADAPTER_ERR_CNT_EN
        // Saturation: preload the counter and issue another error write.
        force dut.u_err_cnt.count = 16'hFFFF;
        #1;
        release dut.u_err_cnt.count;
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0000_0009;
        tick();
        req_valid = 1'b0;
        tick();
        error = 1'b1;
        tick();
        error = 1'b0;
        check("sat_rsp_error", rsp_error, 1);
        tick();
        check("sat_err_cnt", err_cnt, 16'hFFFF);
`endif

        // Latency 0 and 7: read_data carries the cycle offset from T.
        req_valid_0 = 1'b1; req_valid_7 = 1'b1; req_write = 1'b0;
        read_data = 32'hA000_0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            req_valid_0 = 1'b0; req_valid_7 = 1'b0;
            read_data = 32'hA000_0000 + k;
            if (k == 1) begin
                check("lat0_read", read_0, 1);
                check("lat7_read", read_7, 1);
            end
            check("lat0_rsp_valid", rsp_valid_0, (k == 2) ? 1 : 0);
            check("lat7_rsp_valid", rsp_valid_7, (k == 9) ? 1 : 0);
            if (k == 2) check("lat0_rsp_rdata", rsp_rdata_0, 32'hA000_0001);
            if (k == 9) check("lat7_rsp_rdata", rsp_rdata_7, 32'hA000_0008);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
